// File: rtl/jinsn_encoder.sv
// Packs (rd, byte offset) requests into RV32I JAL words behind a 2-entry valid/ready FIFO.
// Optional offset legality checking is enabled by defining JENC_RANGE_CHECK_EN.
module jinsn_encoder #(
  parameter int unsigned CNT_W  = 16,
  parameter logic [6:0]  OPCODE = 7'b1101111
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic             out_err,
  output logic             err_seen,
  output logic [CNT_W-1:0] insn_count
);

  localparam logic [31:0] NopInsn = 32'h0000_0013;

  logic [31:0]      insn_q [2];
  logic [1:0]       err_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] count_q;

  logic [31:0] enc_insn;
  logic [31:0] wr_insn;
  logic        wr_err;
  logic        push, pop;

  assign enc_insn = {in_offset[20], in_offset[10:1], in_offset[11], in_offset[19:12],
                     in_rd, OPCODE};

`ifdef JENC_RANGE_CHECK_EN
  logic illegal;
  logic err_seen_q;

  // Legal offsets are even and sign-extend cleanly from bit 20.
  assign illegal = in_offset[0] | (in_offset[31:20] != {12{in_offset[20]}});
  assign wr_insn = illegal ? NopInsn : enc_insn;
  assign wr_err  = illegal;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_seen_q <= 1'b0;
    end else if (push && illegal) begin
      err_seen_q <= 1'b1;
    end
  end

  assign err_seen = err_seen_q;
`else
  logic unused_off;

  assign unused_off = ^{in_offset[31:21], in_offset[0], NopInsn};
  assign wr_insn    = enc_insn;
  assign wr_err     = 1'b0;
  assign err_seen   = 1'b0;
`endif

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      insn_q[0] <= '0;
      insn_q[1] <= '0;
      err_q     <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      count_q   <= '0;
    end else begin
      if (push) begin
        insn_q[wr_ptr_q] <= wr_insn;
        err_q[wr_ptr_q]  <= wr_err;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        count_q  <= count_q + CNT_W'(1);
      end
      occ_q <= occ_d;
    end
  end

  // Outputs read as zero whenever the FIFO is empty, including straight out of reset.
  assign out_insn   = out_valid ? insn_q[rd_ptr_q] : '0;
  assign out_err    = out_valid & err_q[rd_ptr_q];
  assign insn_count = count_q;

endmodule
